// File: rtl/counter_prescaled.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescaled
// Description : Up/down counter with a programmable range (0..limit) and a
//               prescaler, in wrap or one-shot mode, with a terminal-count
//               pulse and a one-shot done level.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescaled #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [0:0]       c_st_run   = 1'b0;
    localparam logic [0:0]       c_st_hold  = 1'b1;
    localparam logic [WIDTH-1:0] c_cnt_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] c_pre_one  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic [PRE_W-1:0] r_pre;
    logic             r_tc;
    logic [0:0]       r_state;

    logic [WIDTH-1:0] w_count_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             w_tc_nxt;
    logic [0:0]       w_state_nxt;
    logic             w_tick;

    assign w_tick = en && (r_pre == prescale);

    always_comb begin
        w_count_nxt = r_count;
        w_pre_nxt   = r_pre;
        w_tc_nxt    = 1'b0;
        w_state_nxt = r_state;
        if (load) begin
            w_count_nxt = load_val;
            w_pre_nxt   = '0;
            w_state_nxt = c_st_run;
        end else begin
            if (en) begin
                w_pre_nxt = w_tick ? '0 : (r_pre + c_pre_one);
            end
            // Ticks only move the count while running; HOLD freezes it.
            if (w_tick && (r_state == c_st_run)) begin
                if (!dir) begin
                    if (r_count >= limit) begin
                        w_tc_nxt = 1'b1;
                        if (oneshot) begin
                            w_count_nxt = limit;
                            w_state_nxt = c_st_hold;
                        end else begin
                            w_count_nxt = '0;
                        end
                    end else begin
                        w_count_nxt = r_count + c_cnt_one;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_tc_nxt = 1'b1;
                        if (oneshot) begin
                            w_count_nxt = '0;
                            w_state_nxt = c_st_hold;
                        end else begin
                            w_count_nxt = limit;
                        end
                    end else begin
                        w_count_nxt = r_count - c_cnt_one;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
            r_state <= c_st_run;
        end else begin
            r_count <= w_count_nxt;
            r_pre   <= w_pre_nxt;
            r_tc    <= w_tc_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = (r_state == c_st_hold);

endmodule
`default_nettype wire

// File: tb/tb_counter_prescaled.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_prescaled
// Description : Self-checking bench for counter_prescaled: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_prescaled;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst, en, dir, oneshot, load;
    logic [WIDTH-1:0] load_val, limit;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             tc, done;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    int m_cnt  = 0;
    int m_pre  = 0;
    int m_tc   = 0;
    int m_done = 0;

    counter_prescaled #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .oneshot  (oneshot),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .prescale (prescale),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented now.
    task automatic model_edge();
        int lim, term_val, wrap_val;
        bit tick, at_end;
        lim = int'(limit);
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_tc = 0; m_done = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_pre = 0; m_tc = 0; m_done = 0;
        end else begin
            tick = en && (m_pre == int'(prescale));
            if (en) m_pre = tick ? 0 : (m_pre + 1) % (1 << PRE_W);
            m_tc = 0;
            if (tick && m_done == 0) begin
                at_end   = dir ? (m_cnt == 0) : (m_cnt >= lim);
                term_val = dir ? 0 : lim;
                wrap_val = dir ? lim : 0;
                if (at_end) begin
                    m_tc = 1;
                    if (oneshot) begin
                        m_cnt  = term_val;
                        m_done = 1;
                    end else begin
                        m_cnt = wrap_val;
                    end
                end else begin
                    m_cnt = (m_cnt + (dir ? -1 : 1) + 256) % 256;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_count"}, int'(count), m_cnt);
        check({tag, "_tc"},    int'(tc),    m_tc);
        check({tag, "_done"},  int'(done),  m_done);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    int tc_seen;

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; oneshot = 1'b0; load = 1'b0;
        load_val = '0; limit = 8'd255; prescale = '0;

        // Reset state
        step("reset");
        check("reset_const_count", int'(count), 0);
        check("reset_const_done", int'(done), 0);

        // Full-range wrap: 256 ticks return to 0 with exactly one tc
        en = 1'b1;
        tc_seen = 0;
        for (int i = 0; i < 256; i++) begin
            step("wrap255");
            if (tc) tc_seen++;
        end
        check("wrap255_final_count", int'(count), 0);
        check("wrap255_tc_pulses", tc_seen, 1);

        // Prescaled range 0..9, then freeze with en=0
        rst = 1'b1; step("rst2");
        limit = 8'd9; prescale = 4'd3;
        for (int i = 0; i < 45; i++) step("pre3");
        en = 1'b0;
        for (int i = 0; i < 5; i++) step("freeze");
        en = 1'b1;
        for (int i = 0; i < 10; i++) step("unfreeze");

        // One-shot down from 3
        prescale = '0; oneshot = 1'b1; dir = 1'b1; load_val = 8'd3; load = 1'b1;
        step("os_load");
        check("os_load_const", int'(count), 3);
        for (int i = 0; i < 6; i++) step("os_down");
        check("os_hold_count", int'(count), 0);
        check("os_hold_done", int'(done), 1);
        load_val = 8'd7; load = 1'b1;
        step("os_reload");
        check("os_reload_done", int'(done), 0);
        check("os_reload_count", int'(count), 7);

        // Priority: rst over load, load over tick
        oneshot = 1'b0; dir = 1'b0;
        rst = 1'b1; load = 1'b1; load_val = 8'd5;
        step("rst_load");
        check("rst_load_const", int'(count), 0);
        load = 1'b1; load_val = 8'd4;
        step("load_tick");
        check("load_tick_tc", int'(tc), 0);

        // load_val above limit, then limit=0 wrap mode
        limit = 8'd5; load_val = 8'd200; load = 1'b1;
        step("over_load");
        step("over_tick");
        check("over_tick_tc", int'(tc), 1);
        limit = 8'd0;
        for (int i = 0; i < 5; i++) step("lim0");

        // Reset from HOLD and mid-prescale
        oneshot = 1'b1; limit = 8'd2;
        for (int i = 0; i < 5; i++) step("to_hold");
        rst = 1'b1; step("rst_hold");
        oneshot = 1'b0; prescale = 4'd4;
        for (int i = 0; i < 7; i++) step("mid_pre");
        rst = 1'b1; step("rst_mid");
        for (int i = 0; i < 12; i++) step("restart");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom % 60) == 0;
            load = ($urandom % 25) == 0;
            en   = ($urandom % 4) != 0;
            load_val = 8'($urandom % 256);
            if (($urandom % 10) == 0) dir      = 1'($urandom);
            if (($urandom % 15) == 0) oneshot  = 1'($urandom);
            if (($urandom % 20) == 0) limit    = (($urandom % 8) == 0) ? 8'd255 : 8'($urandom % 12);
            if (($urandom % 20) == 0) prescale = 4'($urandom % 4);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
